// File: rtl/ascon_arbiter.sv
// ascon_arbiter
// Shares one ascon_core between two clients. A client is granted the core for
// one whole operation (AEAD encrypt, AEAD decrypt or hash). Ties are broken
// round-robin at operation boundaries.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   c{0,1}_key*              client key stream (valid/ready)
//   c{0,1}_bdi*              client data-in stream plus type/eot/eoi/decrypt/hash
//   c{0,1}_bdo*              client data-out stream (valid/ready) plus type/eot
//   c{0,1}_auth*             client authentication result (valid/ready)
//   core_*                   the same streams toward ascon_core, directions inverted
//   gnt                      one-hot grant, 00 while idle
//   op_done                  single-cycle pulse on the operation's final handshake
module ascon_arbiter #(
  parameter int unsigned CCW  = 32,
  parameter int unsigned CCSW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // client 0
  input  logic [CCSW-1:0] c0_key,
  input  logic            c0_key_valid,
  output logic            c0_key_ready,
  input  logic [CCW-1:0]  c0_bdi,
  input  logic            c0_bdi_valid,
  output logic            c0_bdi_ready,
  input  logic [3:0]      c0_bdi_type,
  input  logic            c0_bdi_eot,
  input  logic            c0_bdi_eoi,
  input  logic            c0_decrypt,
  input  logic            c0_hash,
  output logic [CCW-1:0]  c0_bdo,
  output logic            c0_bdo_valid,
  input  logic            c0_bdo_ready,
  output logic [3:0]      c0_bdo_type,
  output logic            c0_bdo_eot,
  output logic            c0_auth,
  output logic            c0_auth_valid,
  input  logic            c0_auth_ready,
  // client 1
  input  logic [CCSW-1:0] c1_key,
  input  logic            c1_key_valid,
  output logic            c1_key_ready,
  input  logic [CCW-1:0]  c1_bdi,
  input  logic            c1_bdi_valid,
  output logic            c1_bdi_ready,
  input  logic [3:0]      c1_bdi_type,
  input  logic            c1_bdi_eot,
  input  logic            c1_bdi_eoi,
  input  logic            c1_decrypt,
  input  logic            c1_hash,
  output logic [CCW-1:0]  c1_bdo,
  output logic            c1_bdo_valid,
  input  logic            c1_bdo_ready,
  output logic [3:0]      c1_bdo_type,
  output logic            c1_bdo_eot,
  output logic            c1_auth,
  output logic            c1_auth_valid,
  input  logic            c1_auth_ready,
  // core side
  output logic [CCSW-1:0] core_key,
  output logic            core_key_valid,
  input  logic            core_key_ready,
  output logic [CCW-1:0]  core_bdi,
  output logic            core_bdi_valid,
  input  logic            core_bdi_ready,
  output logic [3:0]      core_bdi_type,
  output logic            core_bdi_eot,
  output logic            core_bdi_eoi,
  output logic            core_decrypt,
  output logic            core_hash,
  input  logic [CCW-1:0]  core_bdo,
  input  logic            core_bdo_valid,
  output logic            core_bdo_ready,
  input  logic [3:0]      core_bdo_type,
  input  logic            core_bdo_eot,
  input  logic            core_auth,
  input  logic            core_auth_valid,
  output logic            core_auth_ready,
  // status
  output logic [1:0]      gnt,
  output logic            op_done
);

  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_TAG   = 4'h4;
  localparam logic [3:0] D_HASH  = 4'h5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     r_state, w_state_next;
  logic [1:0] r_gnt, w_gnt_next;
  logic       r_last, w_last_next;
  logic       r_armed, w_armed_next;

  logic w_req0, w_req1, w_busy, w_sel1;
  logic w_bdo_ready_sel, w_auth_ready_sel;
  logic w_auth_valid_g, w_auth_ready_g, w_done;

  // An operation can only start with a key, a nonce, or the first AD word of a hash.
  assign w_req0 = c0_key_valid |
                  (c0_bdi_valid & ((c0_bdi_type == D_NONCE) | ((c0_bdi_type == D_AD) & c0_hash)));
  assign w_req1 = c1_key_valid |
                  (c1_bdi_valid & ((c1_bdi_type == D_NONCE) | ((c1_bdi_type == D_AD) & c1_hash)));

  assign w_busy = (r_state == BUSY);
  assign w_sel1 = r_gnt[1];

  assign w_bdo_ready_sel  = w_sel1 ? c1_bdo_ready  : c0_bdo_ready;
  assign w_auth_ready_sel = w_sel1 ? c1_auth_ready : c0_auth_ready;

  // The auth path opens only after the core has been seen with auth_valid low,
  // so a result left over from the previous owner never reaches the new one.
  assign w_auth_valid_g = w_busy & core_auth_valid & r_armed;
  assign w_auth_ready_g = w_busy & w_auth_ready_sel & r_armed;

  assign w_done = w_busy &
                  ((core_bdo_valid & w_bdo_ready_sel & core_bdo_eot &
                    ((core_bdo_type == D_TAG) | (core_bdo_type == D_HASH))) |
                   (w_auth_valid_g & w_auth_ready_g));

  assign op_done = w_done;
  assign gnt     = r_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_last  <= w_last_next;
      r_armed <= w_armed_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_last_next  = r_last;
    w_armed_next = r_armed;
    case (r_state)
      IDLE: begin
        w_armed_next = 1'b0;
        if (w_req0 && w_req1) begin
          w_gnt_next   = r_last ? 2'b01 : 2'b10;
          w_state_next = BUSY;
        end else if (w_req0) begin
          w_gnt_next   = 2'b01;
          w_state_next = BUSY;
        end else if (w_req1) begin
          w_gnt_next   = 2'b10;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_done) begin
          w_last_next  = w_sel1;
          w_gnt_next   = 2'b00;
          w_state_next = IDLE;
        end else if (!core_auth_valid) begin
          w_armed_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = 2'b00;
      end
    endcase
  end

  // Zero-latency steering of the granted client onto the core; everything
  // that is not owned is held at zero.
  always_comb begin
    core_key        = '0;
    core_key_valid  = 1'b0;
    core_bdi        = '0;
    core_bdi_valid  = 1'b0;
    core_bdi_type   = 4'h0;
    core_bdi_eot    = 1'b0;
    core_bdi_eoi    = 1'b0;
    core_decrypt    = 1'b0;
    core_hash       = 1'b0;
    core_bdo_ready  = 1'b0;
    core_auth_ready = 1'b0;
    c0_key_ready    = 1'b0;
    c0_bdi_ready    = 1'b0;
    c0_bdo          = '0;
    c0_bdo_valid    = 1'b0;
    c0_bdo_type     = 4'h0;
    c0_bdo_eot      = 1'b0;
    c0_auth         = 1'b0;
    c0_auth_valid   = 1'b0;
    c1_key_ready    = 1'b0;
    c1_bdi_ready    = 1'b0;
    c1_bdo          = '0;
    c1_bdo_valid    = 1'b0;
    c1_bdo_type     = 4'h0;
    c1_bdo_eot      = 1'b0;
    c1_auth         = 1'b0;
    c1_auth_valid   = 1'b0;
    if (w_busy) begin
      core_bdo_ready  = w_bdo_ready_sel;
      core_auth_ready = w_auth_ready_g;
      if (w_sel1) begin
        core_key       = c1_key;
        core_key_valid = c1_key_valid;
        core_bdi       = c1_bdi;
        core_bdi_valid = c1_bdi_valid;
        core_bdi_type  = c1_bdi_type;
        core_bdi_eot   = c1_bdi_eot;
        core_bdi_eoi   = c1_bdi_eoi;
        core_decrypt   = c1_decrypt;
        core_hash      = c1_hash;
        c1_key_ready   = core_key_ready;
        c1_bdi_ready   = core_bdi_ready;
        c1_bdo         = core_bdo;
        c1_bdo_valid   = core_bdo_valid;
        c1_bdo_type    = core_bdo_type;
        c1_bdo_eot     = core_bdo_eot;
        c1_auth_valid  = w_auth_valid_g;
        c1_auth        = w_auth_valid_g & core_auth;
      end else begin
        core_key       = c0_key;
        core_key_valid = c0_key_valid;
        core_bdi       = c0_bdi;
        core_bdi_valid = c0_bdi_valid;
        core_bdi_type  = c0_bdi_type;
        core_bdi_eot   = c0_bdi_eot;
        core_bdi_eoi   = c0_bdi_eoi;
        core_decrypt   = c0_decrypt;
        core_hash      = c0_hash;
        c0_key_ready   = core_key_ready;
        c0_bdi_ready   = core_bdi_ready;
        c0_bdo         = core_bdo;
        c0_bdo_valid   = core_bdo_valid;
        c0_bdo_type    = core_bdo_type;
        c0_bdo_eot     = core_bdo_eot;
        c0_auth_valid  = w_auth_valid_g;
        c0_auth        = w_auth_valid_g & core_auth;
      end
    end
  end

endmodule

// File: doc/ascon_arbiter.md
# ascon_arbiter

Two-client arbiter that shares a single `ascon_core` instance between two independent requesters (client 0 and client 1). It sits between the clients' key/bdi/bdo/auth streams and the core, and grants the core to one client for one complete operation at a time. Arbitration is round-robin at operation boundaries. An operation is AEAD encrypt, AEAD decrypt or hash. The block also blocks stale `auth_valid` from leaking across grants.

## Interface
- `CCW`, 32, bdi/bdo word width (matches core)
- `CCSW`, 32, key word width (matches core)
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `c{0,1}_key`  in  CCSW  client key word; `c{0,1}_key_valid` in 1; `c{0,1}_key_ready` out 1
- `c{0,1}_bdi`  in  CCW  client data-in; `c{0,1}_bdi_valid` in 1; `c{0,1}_bdi_ready` out 1
- `c{0,1}_bdi_type` in 4, `c{0,1}_bdi_eot` in 1, `c{0,1}_bdi_eoi` in 1, `c{0,1}_decrypt` in 1, `c{0,1}_hash` in 1
- `c{0,1}_bdo`  out  CCW; `c{0,1}_bdo_valid` out 1; `c{0,1}_bdo_ready` in 1; `c{0,1}_bdo_type` out 4; `c{0,1}_bdo_eot` out 1
- `c{0,1}_auth` out 1; `c{0,1}_auth_valid` out 1; `c{0,1}_auth_ready` in 1
- `core_*`  same set mirrored toward `ascon_core`: the directions are inverted, and the widths and names match the core's ports.
- `gnt`  out  2  one-hot grant (00 when idle)
- `op_done`  out  1  single-cycle pulse on operation completion

## Operation
- FSM states: IDLE, BUSY.
- Request from client i (combinational):
  - `key_valid`, or
  - `bdi_valid & bdi_type==D_NONCE`, or
  - `bdi_valid & bdi_type==D_AD & hash`.
- IDLE:
  - All core inputs are driven inactive: valids 0, `bdo_ready` 0, `auth_ready` 0, data 0.
  - All client outputs are 0.
  - Requests are evaluated every cycle.
  - One requester: grant it.
  - Both requesting: grant the client that is not `last`.
  - Register `gnt`, then go to BUSY.
- BUSY:
  - The granted client's inputs are muxed combinationally to `core_*`.
  - Core outputs `key_ready`, `bdi_ready`, `bdo*` are routed to the granted client only.
  - The other client sees all outputs 0. Its inputs are ignored.
- Auth arming:
  - Flag `armed` is cleared on entering BUSY.
  - It sets on the first BUSY cycle where `core_auth_valid==0`.
  - `cX_auth_valid = core_auth_valid & armed`. `core_auth_ready = cX_auth_ready & armed`.
  - `cX_auth = core_auth` when `cX_auth_valid`, else 0.
- End of operation (in BUSY), any one of:
  - `core_bdo_valid & core_bdo_ready & core_bdo_eot` with `core_bdo_type` D_TAG or D_HASH.
  - `cX_auth_valid & cX_auth_ready`.
- On end of operation:
  - Pulse `op_done`.
  - Set `last` to the granted client.
  - Clear `gnt` and go to IDLE.
- `last` resets to 1, so client 0 wins the first tie.

## Timing
- Reset values: `gnt`=00, `op_done`=0, FSM=IDLE, `armed`=0, `last`=1, all client and core-side outputs 0.
- Reset is asserted asynchronously. Outputs go to reset values immediately, without waiting for a clock edge.
- Reset during BUSY abandons the operation. Resetting the core is the integrator's duty.
- Grant latency: a request visible in cycle N gives `gnt` and forwarding in cycle N+1. The core sees the first valid in N+1.
- Release: end handshake in cycle M gives IDLE in M+1. The next grant is at M+2 at the earliest.
- This idle gap guarantees the core has returned to its own IDLE before the next request.
- Forwarding adds no registers: zero-latency combinational paths in BUSY.
- A request that appears in the same cycle as the end handshake is not considered until IDLE.
- Client inputs during a grant to the other client receive no ready. Client valids must be held (standard valid/ready).
- `bdo_ready` of a non-granted client never reaches the core.
- `hash` and `decrypt` are forwarded live. Clients hold them stable for the whole operation.

## Test plan
- Single encrypt on client 0:
  - Stimulus: key 4 words, nonce 4 words, AD 2 words, PT 2 words, all-zero key/nonce.
  - `gnt`=01 one cycle after `key_valid`.
  - Tag of 4 words appears on `c0_bdo` with `bdo_type`=D_TAG.
  - `op_done` pulses with the tag `eot` handshake. `gnt`=00 on the next cycle.
- Contention:
  - Stimulus: both clients raise a hash request (D_AD, `hash`=1) in the same cycle after reset.
  - Client 0 is served first. Client 1 receives no `bdi_ready` until client 0's D_HASH `eot` handshake.
  - `gnt`=10 exactly two cycles after that handshake.
- Round-robin fairness:
  - Stimulus: both clients request continuously for 6 operations.
  - Grants alternate 01,10,01,10,01,10. `op_done` count = 6.
- Stale auth masking:
  - Stimulus: client 1 decrypt with a bad tag, then client 0 encrypt immediately.
  - Client 1 gets `auth_valid`=1, `auth`=0.
  - During client 0's first grant cycle `core_auth_valid`=1 but `c0_auth_valid` stays 0.
  - The operation ends on the tag, not on auth.
- Backpressure:
  - Stimulus: `c0_bdo_ready` toggles 0/1 during PT and tag output.
  - `core_bdo_ready` mirrors it. No word is lost or duplicated.
  - `c1_bdo_valid` stays 0 throughout.
- Async reset mid-operation:
  - Stimulus: `rst` low for 3 ns between clock edges during client 0 AD absorption.
  - `gnt`=00 and `c0_bdi_ready`=0 before the next edge.
  - After release, a new client 1 request is granted with `gnt`=10.
